// File: rtl/sid_osc_bank.sv
// Time-multiplexed SID oscillator bank: one shared phase/LFSR/waveform datapath swept over all voices per CLKen tick.
// Optional feature macro: SID_BANK_RINGSYNC_EN enables ring modulation and hard sync between neighbouring voices.
module sid_osc_bank #(
  parameter int unsigned NUM_VOICES = 3,
  parameter int unsigned ACC_WIDTH  = 24,
  parameter int unsigned BASE_ADDR  = 0,
  parameter int unsigned REG_STRIDE = 7
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    CLKen,
  input  logic                    WR,
  input  logic [4:0]              ADDR,
  input  logic [7:0]              DATA,
  output logic [12*NUM_VOICES-1:0] OUTPUT,
  output logic [NUM_VOICES-1:0]   MSBOUT,
  output logic                    VALID,
  output logic                    BUSY,
  output logic                    OVERRUN
);

  localparam int unsigned SW   = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int unsigned TAP  = ACC_WIDTH - 5;
  localparam logic [SW-1:0] LAST = SW'(NUM_VOICES - 1);
  localparam logic [22:0] LFSR_SEED = 23'h7FFFFF;

  // Control register bit positions (stored as DATA[7:1])
  localparam int unsigned C_SYNC  = 0;
  localparam int unsigned C_RING  = 1;
  localparam int unsigned C_TEST  = 2;
  localparam int unsigned C_TRI   = 3;
  localparam int unsigned C_SAW   = 4;
  localparam int unsigned C_PULSE = 5;
  localparam int unsigned C_NOISE = 6;

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t           state, state_nx;
  logic [SW-1:0]    slot, slot_nx;
  logic             valid_nx, busy_nx, overrun_nx, snap;

  logic [15:0]          freq  [NUM_VOICES];
  logic [11:0]          pw    [NUM_VOICES];
  logic [6:0]           ctrl  [NUM_VOICES];
  logic [ACC_WIDTH-1:0] phase [NUM_VOICES];
  logic [22:0]          lfsr  [NUM_VOICES];
  logic [11:0]          wave  [NUM_VOICES];

  logic [6:0]           c;
  logic [ACC_WIDTH-1:0] cur_phase, new_phase;
  logic [22:0]          new_lfsr;
  logic [11:0]          top, saw_w, pulse_w, tri_w, noise_w, mix;
  logic                 ring_msb, sync_hit;

  function automatic logic hit(input logic [4:0] a, input int unsigned v, input int unsigned k);
    return {27'd0, a} == 32'(BASE_ADDR + v * REG_STRIDE + k);
  endfunction

  // Bus register file
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int unsigned v = 0; v < NUM_VOICES; v++) begin
        freq[v] <= '0;
        pw[v]   <= 12'h800;
        ctrl[v] <= '0;
      end
    end else if (WR) begin
      for (int unsigned v = 0; v < NUM_VOICES; v++) begin
        if (hit(ADDR, v, 0)) freq[v][7:0]  <= DATA;
        if (hit(ADDR, v, 1)) freq[v][15:8] <= DATA;
        if (hit(ADDR, v, 2)) pw[v][7:0]    <= DATA;
        if (hit(ADDR, v, 3)) pw[v][11:8]   <= DATA[3:0];
        if (hit(ADDR, v, 4)) ctrl[v]       <= DATA[7:1];
      end
    end
  end

  assign c = ctrl[slot];

`ifdef SID_BANK_RINGSYNC_EN
  logic [NUM_VOICES-1:0] msb_prev;
  logic [SW-1:0]         src;

  // Source v-1 is already updated this sweep; for slot 0 its MSB is still the pre-sweep value.
  assign src      = (slot == '0) ? LAST : slot - SW'(1);
  assign sync_hit = c[C_SYNC] & msb_prev[src] & ~MSBOUT[src];
  assign ring_msb = c[C_RING] & MSBOUT[src];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)       msb_prev <= '0;
    else if (snap) msb_prev <= MSBOUT;
  end
`else
  logic unused_ringsync;
  assign sync_hit        = 1'b0;
  assign ring_msb        = 1'b0;
  assign unused_ringsync = ^{c[C_RING], c[C_SYNC], snap};
`endif

  // Shared per-slot datapath
  always_comb begin
    cur_phase = phase[slot];
    if (c[C_TEST])     new_phase = '0;
    else if (sync_hit) new_phase = '0;
    else               new_phase = cur_phase + ACC_WIDTH'(freq[slot]);

    new_lfsr = lfsr[slot];
    if (c[C_TEST])
      new_lfsr = LFSR_SEED;
    else if (!cur_phase[TAP] && new_phase[TAP])
      new_lfsr = {lfsr[slot][21:0], lfsr[slot][22] ^ lfsr[slot][21]};

    top     = new_phase[ACC_WIDTH-1 -: 12];
    saw_w   = top;
    pulse_w = (top >= pw[slot]) ? 12'h000 : 12'hFFF;
    tri_w   = (new_phase[ACC_WIDTH-1] ^ ring_msb) ? new_phase[ACC_WIDTH-2 -: 12]
                                                  : ~new_phase[ACC_WIDTH-2 -: 12];
    noise_w = {new_lfsr[20], new_lfsr[18], new_lfsr[14], new_lfsr[11],
               new_lfsr[9], new_lfsr[5], new_lfsr[2], new_lfsr[0], 4'b0000};

    mix = 12'hFFF;
    if (c[C_NOISE]) mix = mix & noise_w;
    if (c[C_PULSE]) mix = mix & pulse_w;
    if (c[C_SAW])   mix = mix & saw_w;
    if (c[C_TRI])   mix = mix & tri_w;
  end

  // Voice state and output slices, written back one slot per cycle
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int unsigned v = 0; v < NUM_VOICES; v++) begin
        phase[v] <= '0;
        lfsr[v]  <= LFSR_SEED;
        wave[v]  <= '0;
      end
      MSBOUT <= '0;
    end else if (state == SWEEP) begin
      phase[slot]  <= new_phase;
      lfsr[slot]   <= new_lfsr;
      wave[slot]   <= ~mix;
      MSBOUT[slot] <= new_phase[ACC_WIDTH-1];
    end
  end

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_out
    assign OUTPUT[12*g +: 12] = wave[g];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      slot    <= '0;
      VALID   <= 1'b0;
      BUSY    <= 1'b0;
      OVERRUN <= 1'b0;
    end else begin
      state   <= state_nx;
      slot    <= slot_nx;
      VALID   <= valid_nx;
      BUSY    <= busy_nx;
      OVERRUN <= overrun_nx;
    end
  end

  // Sweep sequencer
  always_comb begin
    state_nx   = state;
    slot_nx    = slot;
    valid_nx   = 1'b0;
    overrun_nx = OVERRUN;
    snap       = 1'b0;
    case (state)
      IDLE: begin
        if (CLKen) begin
          state_nx = SWEEP;
          slot_nx  = '0;
          snap     = 1'b1;
        end
      end
      SWEEP: begin
        if (CLKen) overrun_nx = 1'b1;
        if (slot == LAST) begin
          state_nx = IDLE;
          slot_nx  = '0;
          valid_nx = 1'b1;
        end else begin
          slot_nx = slot + SW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
    busy_nx = (state_nx == SWEEP);
  end

endmodule

// File: tb/tb_sid_osc_bank.sv
// Directed self-checking bench for sid_osc_bank (N=3, 24-bit accumulator); sync checks follow SID_BANK_RINGSYNC_EN.
module tb_sid_osc_bank;
  logic        CLK = 1'b0;
  logic        RST, CLKen, WR;
  logic [4:0]  ADDR;
  logic [7:0]  DATA;
  logic [35:0] OUTPUT;
  logic [2:0]  MSBOUT;
  logic        VALID, BUSY, OVERRUN;

  int passed = 0;
  int failed = 0;
  int total  = 0;
  int nv;

  always #5 CLK = ~CLK;

  sid_osc_bank dut (
    .CLK(CLK), .RST(RST), .CLKen(CLKen), .WR(WR), .ADDR(ADDR), .DATA(DATA),
    .OUTPUT(OUTPUT), .MSBOUT(MSBOUT), .VALID(VALID), .BUSY(BUSY), .OVERRUN(OVERRUN)
  );

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    @(negedge CLK); WR = 1'b1; ADDR = a; DATA = d;
    @(negedge CLK); WR = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge CLK); RST = 1'b1;
    @(negedge CLK); RST = 1'b0;
  endtask

  // One CLKen pulse, then wait (bounded) for VALID; expect it 3 cycles later
  task automatic tick();
    int k;
    @(negedge CLK); CLKen = 1'b1;
    @(negedge CLK); CLKen = 1'b0;
    k = 0;
    while (VALID !== 1'b1 && k < 20) begin
      @(negedge CLK);
      k++;
    end
    chk("valid_lat", 36'(k), 36'd3);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; CLKen = 1'b0; WR = 1'b0; ADDR = '0; DATA = '0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    chk("rst_out",     OUTPUT,  36'd0);
    chk("rst_msb",     36'(MSBOUT), 36'd0);
    chk("rst_valid",   36'(VALID),  36'd0);
    chk("rst_busy",    36'(BUSY),   36'd0);
    chk("rst_overrun", 36'(OVERRUN), 36'd0);

    // Frequency set but no waveform enabled
    wr(5'd0, 8'h00); wr(5'd1, 8'h10);
    tick();
    chk("off_out", OUTPUT, 36'd0);

    // Saw on voice 0; writes to unmapped offsets must not disturb anything
    do_reset();
    wr(5'd5, 8'hFF); wr(5'd6, 8'hFF);
    wr(5'd0, 8'h00); wr(5'd1, 8'h10); wr(5'd4, 8'h20);
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk("saw", 36'(OUTPUT[11:0]), 36'(12'hFFF - 12'(i)));
      if (i == 1) begin
        @(negedge CLK);
        chk("valid_one_cycle", 36'(VALID), 36'd0);
        chk("busy_done",       36'(BUSY),  36'd0);
      end
    end
    chk("saw_others", 36'(OUTPUT[35:12]), 36'd0);

    // Pulse with default pw = 0x800, top steps by 8 per tick
    do_reset();
    wr(5'd0, 8'h00); wr(5'd1, 8'h80); wr(5'd4, 8'h40);
    tick();
    chk("pulse_first", 36'(OUTPUT[11:0]), 36'd0);
    repeat (254) tick();
    chk("pulse_below", 36'(OUTPUT[11:0]), 36'd0);
    chk("pulse_msb_lo", 36'(MSBOUT), 36'd0);
    tick();
    chk("pulse_at", 36'(OUTPUT[11:0]), 36'hFFF);
    chk("pulse_msb_hi", 36'(MSBOUT), 36'b001);
    wr(5'd2, 8'h00); wr(5'd3, 8'h09);
    tick();
    chk("pulse_pw", 36'(OUTPUT[11:0]), 36'd0);

    // Test bit holds phase/LFSR, then noise shifts on each bit-19 rise (ticks 16, 48, 80)
    do_reset();
    wr(5'd0, 8'h00); wr(5'd1, 8'h80); wr(5'd4, 8'h88);
    repeat (2) begin
      tick();
      chk("test_noise", 36'(OUTPUT[11:0]), 36'h00F);
      chk("test_msb",   36'(MSBOUT), 36'd0);
    end
    wr(5'd4, 8'h80);
    repeat (15) tick();
    chk("noise_pre",  36'(OUTPUT[11:0]), 36'h00F);
    tick();
    chk("noise_1st",  36'(OUTPUT[11:0]), 36'h01F);
    repeat (63) tick();
    chk("noise_hold", 36'(OUTPUT[11:0]), 36'h01F);
    tick();
    chk("noise_3rd",  36'(OUTPUT[11:0]), 36'h03F);

    // Voice 1 synced to voice 0 (freq 0x8000, MSB falls on tick 512)
    do_reset();
    wr(5'd0, 8'h00); wr(5'd1, 8'h80);
    wr(5'd7, 8'h23); wr(5'd8, 8'h01); wr(5'd11, 8'h22);
    repeat (256) tick();
    chk("sync_rise_out", 36'(OUTPUT[23:12]), 36'hFED);
    chk("sync_rise_msb", 36'(MSBOUT[0]), 36'd1);
    repeat (255) tick();
    chk("sync_pre_out", 36'(OUTPUT[23:12]), 36'hFDB);
    chk("sync_pre_msb", 36'(MSBOUT[0]), 36'd1);
    tick();
    chk("sync_fall_msb", 36'(MSBOUT[0]), 36'd0);
`ifdef SID_BANK_RINGSYNC_EN
    chk("sync_fall_out", 36'(OUTPUT[23:12]), 36'hFFF);
    repeat (16) tick();
    chk("sync_after", 36'(OUTPUT[23:12]), 36'hFFE);
`else
    chk("nosync_fall_out", 36'(OUTPUT[23:12]), 36'hFDB);
    repeat (16) tick();
    chk("nosync_after", 36'(OUTPUT[23:12]), 36'hFDA);
`endif

    // Reset in the middle of a sweep
    do_reset();
    wr(5'd0, 8'h00); wr(5'd1, 8'h10); wr(5'd4, 8'h20);
    repeat (3) tick();
    chk("mid_pre", 36'(OUTPUT[11:0]), 36'hFFC);
    @(negedge CLK); CLKen = 1'b1;
    @(negedge CLK); CLKen = 1'b0;
    chk("mid_busy", 36'(BUSY), 36'd1);
    @(negedge CLK);
    chk("mid_slice0", 36'(OUTPUT[11:0]), 36'hFFB);
    RST = 1'b1;
    #1;
    chk("mid_rst_out",   OUTPUT, 36'd0);
    chk("mid_rst_busy",  36'(BUSY), 36'd0);
    chk("mid_rst_msb",   36'(MSBOUT), 36'd0);
    chk("mid_rst_valid", 36'(VALID), 36'd0);
    @(negedge CLK); RST = 1'b0;
    wr(5'd0, 8'h00); wr(5'd1, 8'h10); wr(5'd4, 8'h20);
    tick();
    chk("mid_restart", 36'(OUTPUT[11:0]), 36'hFFE);

    // Overrun: second CLKen two cycles after the first
    do_reset();
    chk("ovr_init", 36'(OVERRUN), 36'd0);
    wr(5'd0, 8'h00); wr(5'd1, 8'h10); wr(5'd4, 8'h20);
    @(negedge CLK); CLKen = 1'b1;
    @(negedge CLK); CLKen = 1'b0;
    @(negedge CLK); CLKen = 1'b1;
    @(negedge CLK); CLKen = 1'b0;
    nv = 0;
    repeat (20) begin
      if (VALID === 1'b1) nv++;
      @(negedge CLK);
    end
    chk("ovr_sweeps", 36'(nv), 36'd1);
    chk("ovr_flag",   36'(OVERRUN), 36'd1);
    chk("ovr_out",    36'(OUTPUT[11:0]), 36'hFFE);
    tick();
    chk("ovr_sticky", 36'(OVERRUN), 36'd1);
    chk("ovr_next",   36'(OUTPUT[11:0]), 36'hFFD);
    do_reset();
    chk("ovr_clear",  36'(OVERRUN), 36'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
